// File: rtl/alloc_multi_pkg.sv
// alloc_multi_pkg: definitions shared by the input-port allocator and its FIFO.
// Contents:
//   - channel / output indices (LOCAL, LEFT, RIGHT, UP, DOWN)
//   - flit-type encodings (taken from the two MSBs of a flit)
//   - allocator FSM state type
//   - is_head / is_tail helpers on a flit type
package alloc_multi_pkg;

  localparam int LOCAL   = 0;
  localparam int LEFT    = 1;
  localparam int RIGHT   = 2;
  localparam int UP      = 3;
  localparam int DOWN    = 4;
  localparam int NUM_OUT = 5;

  localparam logic [1:0] FLIT_HEAD   = 2'b00;
  localparam logic [1:0] FLIT_BODY   = 2'b01;
  localparam logic [1:0] FLIT_TAIL   = 2'b10;
  localparam logic [1:0] FLIT_SINGLE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_FWD  = 2'b01,
    ST_DROP = 2'b10
  } state_t;

  // A flit opens a packet when it carries a route: HEAD or SINGLE.
  function automatic logic is_head(input logic [1:0] ftype);
    return (ftype == FLIT_HEAD) || (ftype == FLIT_SINGLE);
  endfunction

  // A flit closes a packet when it is TAIL or SINGLE.
  function automatic logic is_tail(input logic [1:0] ftype);
    return (ftype == FLIT_TAIL) || (ftype == FLIT_SINGLE);
  endfunction

endpackage

// File: rtl/alloc_fifo.sv
// alloc_fifo: synchronous first-word-fall-through FIFO.
// Ports:
//   clk, rst  - clock, synchronous active-high reset (empties the FIFO)
//   push      - write wdata this cycle (ignored while full, even with a pop)
//   wdata     - write data
//   pop       - discard the head entry this cycle (ignored while empty)
//   rdata     - current head entry, valid whenever empty is low
//   full      - all FIFO_DEPTH entries occupied
//   empty     - no entries occupied
module alloc_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  full,
  output logic                  empty
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem_r [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_r;
  logic [AW-1:0]         rd_ptr_r;
  logic [AW:0]           count_r;
  logic                  do_push_s;
  logic                  do_pop_s;

  assign full      = (count_r == DEPTH_C);
  assign empty     = (count_r == '0);
  assign do_push_s = push & ~full;
  assign do_pop_s  = pop & ~empty;
  assign rdata     = mem_r[rd_ptr_r];

  // Storage array; contents need no reset because count_r gates visibility.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1'b1);
        2'b01:   count_r <= count_r - (AW+1)'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/alloc_multi.sv
// alloc_multi: input-port allocator for one mesh-router input channel.
// Buffers flits in a FWFT FIFO, routes head/single flits Y-first then X,
// holds the chosen output for the whole wormhole packet and drops illegally
// routed packets and orphan body/tail flits.
// Ports:
//   clk, rst    - clock, synchronous active-high reset
//   data_i      - incoming flit; valid_i/ready_o handshake with upstream
//   valid_o[5]  - one-hot (or zero) request to LOCAL/LEFT/RIGHT/UP/DOWN
//   ready_i[5]  - grants from the downstream arbiters
//   data_o      - FIFO head flit, shared by all outputs
//   err_o       - one-cycle pulse per dropped packet or orphan flit
//   pkt_cnt_o   - forwarded packets (wrapping)
//   drop_cnt_o  - drop events (wrapping)
module alloc_multi
  import alloc_multi_pkg::*;
#(
  parameter int CHANNEL_ID  = LEFT,
  parameter int ROUTER_ID_X = 0,
  parameter int ROUTER_ID_Y = 0,
  parameter int DATA_WIDTH  = 32,
  parameter int RTID_LSB    = 0,
  parameter int RTID_W      = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic [4:0]            valid_o,
  input  logic [4:0]            ready_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  err_o,
  output logic [CNT_W-1:0]      pkt_cnt_o,
  output logic [CNT_W-1:0]      drop_cnt_o
);

  localparam int HW = RTID_W / 2;
  localparam logic [HW-1:0] MY_X = HW'(ROUTER_ID_X);
  localparam logic [HW-1:0] MY_Y = HW'(ROUTER_ID_Y);

  logic [DATA_WIDTH-1:0] head_flit_s;
  logic                  fifo_full_s;
  logic                  fifo_empty_s;
  logic                  push_s;
  logic                  pop_s;
  logic [1:0]            ftype_s;
  logic [RTID_W-1:0]     rtid_s;
  logic [2:0]            route_s;
  logic                  illegal_s;
  logic                  drop_evt_s;
  logic [4:0]            valid_s;

  state_t                state_r;
  logic [2:0]            route_reg_r;
  logic                  err_r;
  logic [CNT_W-1:0]      pkt_cnt_r;
  logic [CNT_W-1:0]      drop_cnt_r;

  // Dimension-order route: settle Y first, then X, then deliver locally.
  function automatic logic [2:0] route_of(input logic [HW-1:0] dx, input logic [HW-1:0] dy);
    if (dy > MY_Y) begin
      return 3'(RIGHT);
    end else if (dy < MY_Y) begin
      return 3'(LEFT);
    end else if (dx > MY_X) begin
      return 3'(DOWN);
    end else if (dx < MY_X) begin
      return 3'(UP);
    end else begin
      return 3'(LOCAL);
    end
  endfunction

  // U-turns are illegal except LOCAL->LOCAL; traffic that already travelled
  // in X (entered on UP/DOWN) may not turn back into Y.
  function automatic logic illegal_route(input logic [2:0] r);
    logic u_turn;
    logic y_after_x;
    u_turn    = (CHANNEL_ID != LOCAL) && (r == 3'(CHANNEL_ID));
    y_after_x = ((CHANNEL_ID == UP) || (CHANNEL_ID == DOWN)) &&
                ((r == 3'(LEFT)) || (r == 3'(RIGHT)));
    return u_turn | y_after_x;
  endfunction

  assign ready_o = ~fifo_full_s & ~rst;
  assign push_s  = valid_i & ready_o;

  alloc_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .wdata (data_i),
    .pop   (pop_s),
    .rdata (head_flit_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  assign ftype_s   = head_flit_s[DATA_WIDTH-1:DATA_WIDTH-2];
  assign rtid_s    = head_flit_s[RTID_LSB +: RTID_W];
  assign route_s   = route_of(rtid_s[RTID_W-1 -: HW], rtid_s[HW-1:0]);
  assign illegal_s = illegal_route(route_s);

  // Request/pop decode from the FIFO head; combinational so a head flit can
  // fire in the cycle it becomes visible.
  always_comb begin
    valid_s    = 5'b00000;
    pop_s      = 1'b0;
    drop_evt_s = 1'b0;
    if (!fifo_empty_s && !rst) begin
      case (state_r)
        ST_IDLE: begin
          if (is_head(ftype_s) && !illegal_s) begin
            valid_s[route_s] = 1'b1;
            pop_s            = ready_i[route_s];
          end else begin
            // Illegal head/single or orphan body/tail: discard at once.
            pop_s      = 1'b1;
            drop_evt_s = 1'b1;
          end
        end
        ST_FWD: begin
          valid_s[route_reg_r] = 1'b1;
          pop_s                = ready_i[route_reg_r];
        end
        ST_DROP: begin
          pop_s = 1'b1;
        end
        default: begin
          pop_s = 1'b0;
        end
      endcase
    end else begin
      pop_s = 1'b0;
    end
  end

  // Packet-lock FSM with registered error pulse and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      route_reg_r <= 3'b000;
      err_r       <= 1'b0;
      pkt_cnt_r   <= '0;
      drop_cnt_r  <= '0;
    end else begin
      err_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (pop_s) begin
            if (drop_evt_s) begin
              err_r      <= 1'b1;
              drop_cnt_r <= drop_cnt_r + CNT_W'(1'b1);
              // Only a multi-flit packet leaves body flits to swallow.
              if (ftype_s == FLIT_HEAD) begin
                state_r <= ST_DROP;
              end else begin
                state_r <= ST_IDLE;
              end
            end else if (is_tail(ftype_s)) begin
              pkt_cnt_r <= pkt_cnt_r + CNT_W'(1'b1);
              state_r   <= ST_IDLE;
            end else begin
              route_reg_r <= route_s;
              state_r     <= ST_FWD;
            end
          end
        end
        ST_FWD: begin
          // Inside a packet only a real TAIL ends it; HEAD/SINGLE pass as body.
          if (pop_s && (ftype_s == FLIT_TAIL)) begin
            pkt_cnt_r <= pkt_cnt_r + CNT_W'(1'b1);
            state_r   <= ST_IDLE;
          end
        end
        ST_DROP: begin
          if (pop_s && (ftype_s == FLIT_TAIL)) begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign valid_o    = valid_s;
  assign data_o     = head_flit_s;
  assign err_o      = err_r;
  assign pkt_cnt_o  = pkt_cnt_r;
  assign drop_cnt_o = drop_cnt_r;

endmodule

// File: tb/tb_alloc_multi.sv
module tb_alloc_multi;
  import alloc_multi_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic [31:0] data_i;
  logic [4:0]  ready_i;

  logic        ready_l, err_l, ready_u, err_u;
  logic [4:0]  valid_l, valid_u;
  logic [31:0] data_l, data_u;
  logic [15:0] pkt_l, drop_l, pkt_u, drop_u;

  int n_chk  = 0;
  int n_fail = 0;

  localparam logic [4:0] V_0   = 5'b00000;
  localparam logic [4:0] V_L   = 5'b00001;
  localparam logic [4:0] V_R   = 5'b00100;
  localparam logic [4:0] V_ALL = 5'b11111;
  localparam logic [1:0] H = 2'b00, B = 2'b01, T = 2'b10, S = 2'b11;

  always #5 clk = ~clk;

  alloc_multi #(.CHANNEL_ID(LEFT), .ROUTER_ID_X(1), .ROUTER_ID_Y(1)) dut_left (
    .clk(clk), .rst(rst), .data_i(data_i), .valid_i(valid_i), .ready_o(ready_l),
    .valid_o(valid_l), .ready_i(ready_i), .data_o(data_l), .err_o(err_l),
    .pkt_cnt_o(pkt_l), .drop_cnt_o(drop_l));

  alloc_multi #(.CHANNEL_ID(UP), .ROUTER_ID_X(1), .ROUTER_ID_Y(1)) dut_up (
    .clk(clk), .rst(rst), .data_i(data_i), .valid_i(valid_i), .ready_o(ready_u),
    .valid_o(valid_u), .ready_i(ready_i), .data_o(data_u), .err_o(err_u),
    .pkt_cnt_o(pkt_u), .drop_cnt_o(drop_u));

  typedef struct {
    logic        rst;
    logic        vin;
    logic [31:0] din;
    logic [4:0]  rdy;
    logic [4:0]  e_vo;
    logic        e_rdy;
    logic        e_err;
    logic [15:0] e_pkt;
    logic [15:0] e_drop;
    logic        chk_d;
    logic [31:0] e_d;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [31:0] fl(input logic [1:0] t, input logic [3:0] x,
                                     input logic [3:0] y, input logic [7:0] tag);
    return {t, 14'd0, tag, x, y};
  endfunction

  function automatic vec_t mk(input logic r, input logic v, input logic [31:0] d,
                              input logic [4:0] rd, input logic [4:0] vo, input logic ro,
                              input logic er, input logic [15:0] pk, input logic [15:0] dr,
                              input logic cd, input logic [31:0] ed);
    vec_t x;
    x.rst = r; x.vin = v; x.din = d; x.rdy = rd; x.e_vo = vo; x.e_rdy = ro;
    x.e_err = er; x.e_pkt = pk; x.e_drop = dr; x.chk_d = cd; x.e_d = ed;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Apply inputs just after a rising edge, then move to the falling edge for sampling.
  task automatic set_in(input logic r, input logic v, input logic [31:0] d, input logic [4:0] rd);
    rst = r; valid_i = v; data_i = d; ready_i = rd;
    @(negedge clk);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    set_in(1'b1, 1'b0, 32'd0, V_0);
    adv();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; valid_i = 1'b0; data_i = 32'd0; ready_i = V_0;
    repeat (2) @(posedge clk);
    #1;

    // rst, vin, din, rdy | valid_o, ready_o, err, pkt, drop, check data, data
    // Reset state
    tbl.push_back(mk(1'b1, 1'b0, 32'd0, V_0, V_0, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0, 32'd0));
    // Test 1: LEFT in, HEAD to (1,3) -> RIGHT, 2 BODY, TAIL; 4 pops in 4 cycles
    tbl.push_back(mk(1'b0, 1'b1, fl(H,4'd1,4'd3,8'h10), V_R, V_0, 1'b1, 1'b0, 16'd0, 16'd0, 1'b0, 32'd0));
    tbl.push_back(mk(1'b0, 1'b1, fl(B,4'd0,4'd0,8'h11), V_R, V_R, 1'b1, 1'b0, 16'd0, 16'd0, 1'b1, fl(H,4'd1,4'd3,8'h10)));
    tbl.push_back(mk(1'b0, 1'b1, fl(B,4'd0,4'd0,8'h12), V_R, V_R, 1'b1, 1'b0, 16'd0, 16'd0, 1'b1, fl(B,4'd0,4'd0,8'h11)));
    tbl.push_back(mk(1'b0, 1'b1, fl(T,4'd0,4'd0,8'h13), V_R, V_R, 1'b1, 1'b0, 16'd0, 16'd0, 1'b1, fl(B,4'd0,4'd0,8'h12)));
    tbl.push_back(mk(1'b0, 1'b0, 32'd0, V_R, V_R, 1'b1, 1'b0, 16'd0, 16'd0, 1'b1, fl(T,4'd0,4'd0,8'h13)));
    tbl.push_back(mk(1'b0, 1'b0, 32'd0, V_R, V_0, 1'b1, 1'b0, 16'd1, 16'd0, 1'b0, 32'd0));
    // Reset between tests (counters not cleared until the edge)
    tbl.push_back(mk(1'b1, 1'b0, 32'd0, V_0, V_0, 1'b0, 1'b0, 16'd1, 16'd0, 1'b0, 32'd0));
    // Test 4: orphan BODY then SINGLE to (1,1) -> LOCAL
    tbl.push_back(mk(1'b0, 1'b1, fl(B,4'd0,4'd0,8'h20), V_L, V_0, 1'b1, 1'b0, 16'd0, 16'd0, 1'b0, 32'd0));
    tbl.push_back(mk(1'b0, 1'b1, fl(S,4'd1,4'd1,8'h21), V_L, V_0, 1'b1, 1'b0, 16'd0, 16'd0, 1'b0, 32'd0));
    tbl.push_back(mk(1'b0, 1'b0, 32'd0, V_L, V_L, 1'b1, 1'b1, 16'd0, 16'd1, 1'b1, fl(S,4'd1,4'd1,8'h21)));
    tbl.push_back(mk(1'b0, 1'b0, 32'd0, V_L, V_0, 1'b1, 1'b0, 16'd1, 16'd1, 1'b0, 32'd0));
    // Test 6: reset mid-packet with 3 flits buffered, then a fresh packet
    tbl.push_back(mk(1'b0, 1'b1, fl(H,4'd1,4'd3,8'h30), V_0, V_0, 1'b1, 1'b0, 16'd1, 16'd1, 1'b0, 32'd0));
    tbl.push_back(mk(1'b0, 1'b1, fl(B,4'd0,4'd0,8'h31), V_R, V_R, 1'b1, 1'b0, 16'd1, 16'd1, 1'b1, fl(H,4'd1,4'd3,8'h30)));
    tbl.push_back(mk(1'b0, 1'b1, fl(B,4'd0,4'd0,8'h32), V_0, V_R, 1'b1, 1'b0, 16'd1, 16'd1, 1'b1, fl(B,4'd0,4'd0,8'h31)));
    tbl.push_back(mk(1'b0, 1'b1, fl(B,4'd0,4'd0,8'h33), V_0, V_R, 1'b1, 1'b0, 16'd1, 16'd1, 1'b1, fl(B,4'd0,4'd0,8'h31)));
    tbl.push_back(mk(1'b1, 1'b0, 32'd0, V_R, V_0, 1'b0, 1'b0, 16'd1, 16'd1, 1'b0, 32'd0));
    tbl.push_back(mk(1'b1, 1'b0, 32'd0, V_R, V_0, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0, 32'd0));
    tbl.push_back(mk(1'b0, 1'b1, fl(H,4'd1,4'd1,8'h34), V_L, V_0, 1'b1, 1'b0, 16'd0, 16'd0, 1'b0, 32'd0));
    tbl.push_back(mk(1'b0, 1'b0, 32'd0, V_L, V_L, 1'b1, 1'b0, 16'd0, 16'd0, 1'b1, fl(H,4'd1,4'd1,8'h34)));
    tbl.push_back(mk(1'b0, 1'b1, fl(T,4'd0,4'd0,8'h35), V_L, V_0, 1'b1, 1'b0, 16'd0, 16'd0, 1'b0, 32'd0));
    tbl.push_back(mk(1'b0, 1'b0, 32'd0, V_L, V_L, 1'b1, 1'b0, 16'd0, 16'd0, 1'b1, fl(T,4'd0,4'd0,8'h35)));
    tbl.push_back(mk(1'b0, 1'b0, 32'd0, V_L, V_0, 1'b1, 1'b0, 16'd1, 16'd0, 1'b0, 32'd0));

    foreach (tbl[i]) begin
      set_in(tbl[i].rst, tbl[i].vin, tbl[i].din, tbl[i].rdy);
      chk($sformatf("tbl%0d valid_o", i), {27'd0, valid_l}, {27'd0, tbl[i].e_vo});
      chk($sformatf("tbl%0d ready_o", i), {31'd0, ready_l}, {31'd0, tbl[i].e_rdy});
      chk($sformatf("tbl%0d err_o", i), {31'd0, err_l}, {31'd0, tbl[i].e_err});
      chk($sformatf("tbl%0d pkt_cnt", i), {16'd0, pkt_l}, {16'd0, tbl[i].e_pkt});
      chk($sformatf("tbl%0d drop_cnt", i), {16'd0, drop_l}, {16'd0, tbl[i].e_drop});
      if (tbl[i].chk_d) begin
        chk($sformatf("tbl%0d data_o", i), data_l, tbl[i].e_d);
      end
      adv();
    end

    // Test 2: downstream stall mid-packet with a LOCAL packet queued behind
    do_reset();
    set_in(1'b0, 1'b1, fl(H,4'd1,4'd3,8'h40), V_R);
    chk("t2 c0 valid_o", {27'd0, valid_l}, {27'd0, V_0}); adv();
    set_in(1'b0, 1'b1, fl(B,4'd0,4'd0,8'h41), V_R);
    chk("t2 c1 valid_o", {27'd0, valid_l}, {27'd0, V_R});
    chk("t2 c1 data_o", data_l, fl(H,4'd1,4'd3,8'h40)); adv();
    set_in(1'b0, 1'b1, fl(T,4'd0,4'd0,8'h42), V_0);
    chk("t2 c2 valid_o", {27'd0, valid_l}, {27'd0, V_R});
    chk("t2 c2 data_o", data_l, fl(B,4'd0,4'd0,8'h41)); adv();
    set_in(1'b0, 1'b1, fl(H,4'd1,4'd1,8'h43), V_0);
    chk("t2 c3 valid_o", {27'd0, valid_l}, {27'd0, V_R});
    chk("t2 c3 data_o", data_l, fl(B,4'd0,4'd0,8'h41)); adv();
    set_in(1'b0, 1'b1, fl(T,4'd0,4'd0,8'h44), V_0);
    chk("t2 c4 valid_o", {27'd0, valid_l}, {27'd0, V_R});
    chk("t2 c4 data_o", data_l, fl(B,4'd0,4'd0,8'h41)); adv();
    set_in(1'b0, 1'b0, 32'd0, V_R);
    chk("t2 c5 ready_o", {31'd0, ready_l}, 32'd0);
    chk("t2 c5 valid_o", {27'd0, valid_l}, {27'd0, V_R});
    chk("t2 c5 data_o", data_l, fl(B,4'd0,4'd0,8'h41)); adv();
    set_in(1'b0, 1'b0, 32'd0, V_R);
    chk("t2 c6 valid_o", {27'd0, valid_l}, {27'd0, V_R});
    chk("t2 c6 data_o", data_l, fl(T,4'd0,4'd0,8'h42));
    chk("t2 c6 pkt_cnt", {16'd0, pkt_l}, 32'd0); adv();
    set_in(1'b0, 1'b0, 32'd0, V_ALL);
    chk("t2 c7 valid_o", {27'd0, valid_l}, {27'd0, V_L});
    chk("t2 c7 data_o", data_l, fl(H,4'd1,4'd1,8'h43));
    chk("t2 c7 pkt_cnt", {16'd0, pkt_l}, 32'd1); adv();
    set_in(1'b0, 1'b0, 32'd0, V_ALL);
    chk("t2 c8 valid_o", {27'd0, valid_l}, {27'd0, V_L});
    chk("t2 c8 data_o", data_l, fl(T,4'd0,4'd0,8'h44)); adv();
    set_in(1'b0, 1'b0, 32'd0, V_0);
    chk("t2 c9 valid_o", {27'd0, valid_l}, {27'd0, V_0});
    chk("t2 c9 pkt_cnt", {16'd0, pkt_l}, 32'd2); adv();

    // Test 3: UP input, HEAD to (2,0) turns into Y -> whole packet dropped
    do_reset();
    set_in(1'b0, 1'b1, fl(H,4'd2,4'd0,8'h50), V_ALL);
    chk("t3 c0 valid_o", {27'd0, valid_u}, {27'd0, V_0});
    chk("t3 c0 ready_o", {31'd0, ready_u}, 32'd1); adv();
    set_in(1'b0, 1'b1, fl(B,4'd0,4'd0,8'h51), V_ALL);
    chk("t3 c1 valid_o", {27'd0, valid_u}, {27'd0, V_0});
    chk("t3 c1 left valid_o", {27'd0, valid_l}, {27'd0, V_0}); adv();
    set_in(1'b0, 1'b1, fl(B,4'd0,4'd0,8'h52), V_ALL);
    chk("t3 c2 valid_o", {27'd0, valid_u}, {27'd0, V_0});
    chk("t3 c2 err_o", {31'd0, err_u}, 32'd1);
    chk("t3 c2 drop_cnt", {16'd0, drop_u}, 32'd1);
    chk("t3 c2 left err_o", {31'd0, err_l}, 32'd1); adv();
    set_in(1'b0, 1'b1, fl(T,4'd0,4'd0,8'h53), V_ALL);
    chk("t3 c3 valid_o", {27'd0, valid_u}, {27'd0, V_0});
    chk("t3 c3 err_o", {31'd0, err_u}, 32'd0); adv();
    set_in(1'b0, 1'b0, 32'd0, V_ALL);
    chk("t3 c4 valid_o", {27'd0, valid_u}, {27'd0, V_0});
    chk("t3 c4 err_o", {31'd0, err_u}, 32'd0); adv();
    set_in(1'b0, 1'b1, fl(S,4'd1,4'd1,8'h54), V_ALL);
    chk("t3 c5 valid_o", {27'd0, valid_u}, {27'd0, V_0});
    chk("t3 c5 err_o", {31'd0, err_u}, 32'd0); adv();
    set_in(1'b0, 1'b0, 32'd0, V_ALL);
    chk("t3 c6 valid_o", {27'd0, valid_u}, {27'd0, V_L});
    chk("t3 c6 data_o", data_u, fl(S,4'd1,4'd1,8'h54));
    chk("t3 c6 err_o", {31'd0, err_u}, 32'd0); adv();
    set_in(1'b0, 1'b0, 32'd0, V_0);
    chk("t3 c7 pkt_cnt", {16'd0, pkt_u}, 32'd1);
    chk("t3 c7 drop_cnt", {16'd0, drop_u}, 32'd1);
    chk("t3 c7 left drop_cnt", {16'd0, drop_l}, 32'd1); adv();

    // Test 5: fill the FIFO with no grants, then free one slot
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_in(1'b0, 1'b1, fl(H,4'd1,4'd3,8'(8'h60 + i)), V_0);
      chk($sformatf("t5 fill%0d ready_o", i), {31'd0, ready_l}, 32'd1);
      adv();
    end
    set_in(1'b0, 1'b1, fl(H,4'd1,4'd3,8'h70), V_R);
    chk("t5 full ready_o", {31'd0, ready_l}, 32'd0);
    chk("t5 full valid_o", {27'd0, valid_l}, {27'd0, V_R});
    chk("t5 full data_o", data_l, fl(H,4'd1,4'd3,8'h60)); adv();
    set_in(1'b0, 1'b1, fl(B,4'd0,4'd0,8'h71), V_0);
    chk("t5 popped ready_o", {31'd0, ready_l}, 32'd1);
    chk("t5 popped data_o", data_l, fl(H,4'd1,4'd3,8'h61)); adv();
    set_in(1'b0, 1'b0, 32'd0, V_0);
    chk("t5 refull ready_o", {31'd0, ready_l}, 32'd0); adv();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
